// File: rtl/sar_value_finder.sv
// Successive-approximation search: drives trial values into an external
// a >= b comparator and recovers a MSB first.
module sar_value_finder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             agreqb,
    output logic [WIDTH-1:0] b_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        TEST,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] trial_d;
    logic [WIDTH-1:0] result_q;
    logic [IW-1:0]    idx_q;
    logic             busy_q;
    logic             done_q;

    // Resolve the current bit, then raise the next lower trial bit.
    always_comb begin
        trial_d = b_q;
        trial_d[idx_q] = agreqb;
        if (idx_q != '0) begin
            trial_d[idx_q - IW'(1)] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            b_q      <= '0;
            idx_q    <= TOP;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= TEST;
                        b_q     <= MSB;
                        idx_q   <= TOP;
                        busy_q  <= 1'b1;
                    end else begin
                        b_q <= '0;
                    end
                end
                TEST: begin
                    b_q <= trial_d;
                    if (idx_q != '0) begin
                        idx_q <= idx_q - IW'(1);
                    end else begin
                        result_q <= trial_d;
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    b_q     <= '0;
                    idx_q   <= TOP;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    b_q     <= '0;
                    idx_q   <= TOP;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign b_out  = b_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_sar_value_finder.sv
// Bench for sar_value_finder: table vectors, corner sequences and
// exhaustive/random sweeps against an arithmetic comparator model.
module tb_sar_value_finder;

    logic       clk = 1'b0;
    logic       reset;
    logic       start8, start4;
    logic [7:0] a8, b8, res8;
    logic [3:0] a4, b4, res4;
    logic       agreqb8, agreqb4;
    logic       busy8, done8, busy4, done4;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign agreqb8 = (a8 >= b8);
    assign agreqb4 = (a4 >= b4);

    sar_value_finder #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .agreqb(agreqb8),
        .b_out(b8), .busy(busy8), .done(done8), .result(res8)
    );

    sar_value_finder #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .agreqb(agreqb4),
        .b_out(b4), .busy(busy4), .done(done4), .result(res4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] res;
        int         repulse;
    } vec_t;

    vec_t tbl[5];

    // Expected trial value at step k: the k resolved top bits of a
    // plus the single probe bit just below them.
    function automatic int trial(input int w, input int a, input int k);
        return ((a >> (w - k)) << (w - k)) | (1 << (w - 1 - k));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] exp_res,
                        input int repulse_k);
        @(negedge clk);
        a8 = a;
        start8 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start8 = (k == repulse_k);
            chk("b_out8", b8, trial(8, a, k));
            chk("busy8", busy8, 1);
            chk("done8_low", done8, 0);
        end
        @(negedge clk);
        start8 = 1'b0;
        chk("done8_pulse", done8, 1);
        chk("busy8_off", busy8, 0);
        chk("result8", res8, exp_res);
        @(negedge clk);
        chk("done8_end", done8, 0);
        chk("b_out8_idle", b8, 0);
    endtask

    task automatic run4(input logic [3:0] a);
        @(negedge clk);
        a4 = a;
        start4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start4 = 1'b0;
            chk("b_out4", b4, trial(4, a, k));
        end
        @(negedge clk);
        chk("done4_pulse", done4, 1);
        chk("result4", res4, a);
        @(negedge clk);
        chk("done4_end", done4, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int d0;
        logic [7:0] r;

        reset = 1'b1;
        start8 = 1'b0;
        start4 = 1'b0;
        a8 = '0;
        a4 = '0;
        tbl[0] = '{8'hB5, 8'hB5, -1};
        tbl[1] = '{8'h00, 8'h00, -1};
        tbl[2] = '{8'hFF, 8'hFF, -1};
        tbl[3] = '{8'h3C, 8'h3C, 3};
        tbl[4] = '{8'hC3, 8'hC3, -1};

        #12;
        chk("rst_b8", b8, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_res8", res8, 0);
        chk("rst_b4", b4, 0);
        chk("rst_res4", res4, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run8(tbl[i].a, tbl[i].res, tbl[i].repulse);
        end

        // Mid-search asynchronous reset.
        run8(8'h5A, 8'h5A, -1);
        @(negedge clk);
        a8 = 8'hB5;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", busy8, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_b8", b8, 0);
        chk("arst_busy8", busy8, 0);
        chk("arst_done8", done8, 0);
        chk("arst_res8", res8, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy8, 0);
        chk("post_rst_b8", b8, 0);

        // Start held high across back-to-back searches.
        @(negedge clk);
        a8 = 8'h3C;
        start8 = 1'b1;
        got = 0;
        d0 = 0;
        for (int c = 0; c < 40 && got < 2; c++) begin
            @(negedge clk);
            if (done8) begin
                if (got == 0) begin
                    chk("held_res0", res8, 8'h3C);
                    d0 = c;
                    a8 = 8'hC3;
                end else begin
                    chk("held_res1", res8, 8'hC3);
                    chk("held_period", c - d0, 10);
                    start8 = 1'b0;
                end
                got++;
            end
        end
        start8 = 1'b0;
        chk("held_count", got, 2);
        repeat (3) @(negedge clk);

        for (int v = 0; v < 256; v++) begin
            run8(v[7:0], v[7:0], -1);
        end
        for (int v = 0; v < 16; v++) begin
            run4(v[3:0]);
        end
        for (int n = 0; n < 20; n++) begin
            r = 8'($urandom_range(0, 255));
            run8(r, r, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
